id_operand_stage: RTL and testbench

- Decode/operand-fetch stage that sits directly upstream of the register file. It decodes the IF/ID instruction, drives both regfile read ports, and forwards results from the EX and MEM stages.
- Detects load-use hazards and inserts bubbles when one occurs.
- Registers the decoded operation and operands into the ID/EX pipeline register consumed by the execute stage.

---
 rtl/id_operand_stage.sv | 207 ++++++++++++++++++++
 tb/tb_id_operand_stage.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_operand_stage.sv
// Decode / operand-fetch stage: decodes the IF/ID word, reads the regfile, forwards
// EX/MEM results, detects load-use hazards and registers the result into ID/EX.
module id_operand_stage #(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_valid_i,
   input  logic [31:0]   if_inst_i,
   input  logic [DW-1:0] if_pc_i,
   input  logic          flush_i,
   input  logic          stall_i,
   output logic          stall_req_o,
   output logic          reg1_oe_o,
   output logic [DW-1:0] reg1_addr_o,
   input  logic [DW-1:0] reg1_data_i,
   output logic          reg2_oe_o,
   output logic [DW-1:0] reg2_addr_o,
   input  logic [DW-1:0] reg2_data_i,
   input  logic          ex_we_i,
   input  logic          ex_is_load_i,
   input  logic [AW-1:0] ex_waddr_i,
   input  logic [DW-1:0] ex_wdata_i,
   input  logic          mem_we_i,
   input  logic [AW-1:0] mem_waddr_i,
   input  logic [DW-1:0] mem_wdata_i,
   output logic          idex_valid_o,
   output logic [DW-1:0] idex_pc_o,
   output logic [5:0]    idex_opcode_o,
   output logic [5:0]    idex_funct_o,
   output logic [DW-1:0] idex_op1_o,
   output logic [DW-1:0] idex_op2_o,
   output logic [DW-1:0] idex_store_data_o,
   output logic          idex_we_o,
   output logic [AW-1:0] idex_waddr_o
);

   typedef enum logic [1:0] {OP2_REG, OP2_SEXT, OP2_ZEXT, OP2_UPPER} op2_sel_e;

   logic [5:0]    w_opcode;
   logic [5:0]    w_funct;
   logic [AW-1:0] w_rs;
   logic [AW-1:0] w_rt;
   logic [AW-1:0] w_rd;
   logic [15:0]   w_imm;
   logic          w_unused_shamt;

   logic          w_reads_rs;
   logic          w_reads_rt;
   logic          w_has_dest;
   logic [AW-1:0] w_dest;
   op2_sel_e      w_op2_sel;

   logic          w_oe1;
   logic          w_oe2;
   logic          w_we;
   logic [AW-1:0] w_waddr;
   logic [DW-1:0] w_src1;
   logic [DW-1:0] w_src2;
   logic [DW-1:0] w_op2;
   logic          w_ex_load_live;
   logic          w_hazard;

   logic          r_valid;
   logic [DW-1:0] r_pc;
   logic [5:0]    r_opcode;
   logic [5:0]    r_funct;
   logic [DW-1:0] r_op1;
   logic [DW-1:0] r_op2;
   logic [DW-1:0] r_store;
   logic          r_we;
   logic [AW-1:0] r_waddr;

   // Priority: r0 reads as zero, then the youngest producer (EX), then MEM, then regfile.
   function automatic logic [DW-1:0] resolve(
      input logic          en,
      input logic [AW-1:0] addr,
      input logic [DW-1:0] rf_data,
      input logic          ex_we,
      input logic [AW-1:0] ex_addr,
      input logic [DW-1:0] ex_data,
      input logic          mem_we,
      input logic [AW-1:0] mem_addr,
      input logic [DW-1:0] mem_data
   );
      if (!en || addr == '0)
         resolve = '0;
      else if (ex_we && ex_addr == addr)
         resolve = ex_data;
      else if (mem_we && mem_addr == addr)
         resolve = mem_data;
      else
         resolve = rf_data;
   endfunction

   assign w_opcode       = if_inst_i[31:26];
   assign w_funct        = if_inst_i[5:0];
   assign w_rs           = AW'(if_inst_i[25:21]);
   assign w_rt           = AW'(if_inst_i[20:16]);
   assign w_rd           = AW'(if_inst_i[15:11]);
   assign w_imm          = if_inst_i[15:0];
   assign w_unused_shamt = ^if_inst_i[10:6];

   always_comb begin
      w_reads_rs = 1'b0;
      w_reads_rt = 1'b0;
      w_has_dest = 1'b0;
      w_dest     = w_rt;
      w_op2_sel  = OP2_REG;
      case (w_opcode)
         6'h00: begin
            w_reads_rs = 1'b1;
            w_reads_rt = 1'b1;
            w_has_dest = 1'b1;
            w_dest     = w_rd;
         end
         6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23: begin
            w_reads_rs = 1'b1;
            w_has_dest = 1'b1;
            w_op2_sel  = OP2_SEXT;
         end
         6'h0C, 6'h0D, 6'h0E: begin
            w_reads_rs = 1'b1;
            w_has_dest = 1'b1;
            w_op2_sel  = OP2_ZEXT;
         end
         6'h0F: begin
            w_has_dest = 1'b1;
            w_op2_sel  = OP2_UPPER;
         end
         6'h2B: begin
            w_reads_rs = 1'b1;
            w_reads_rt = 1'b1;
            w_op2_sel  = OP2_SEXT;
         end
         default: ;
      endcase
   end

   assign w_oe1   = if_valid_i & w_reads_rs;
   assign w_oe2   = if_valid_i & w_reads_rt;
   assign w_we    = if_valid_i & w_has_dest & (w_dest != '0);
   assign w_waddr = w_has_dest ? w_dest : '0;

   assign w_src1 = resolve(w_oe1, w_rs, reg1_data_i, ex_we_i, ex_waddr_i, ex_wdata_i,
                           mem_we_i, mem_waddr_i, mem_wdata_i);
   assign w_src2 = resolve(w_oe2, w_rt, reg2_data_i, ex_we_i, ex_waddr_i, ex_wdata_i,
                           mem_we_i, mem_waddr_i, mem_wdata_i);

   always_comb begin
      w_op2 = w_src2;
      case (w_op2_sel)
         OP2_SEXT:  w_op2 = {{(DW-16){w_imm[15]}}, w_imm};
         OP2_ZEXT:  w_op2 = {{(DW-16){1'b0}}, w_imm};
         OP2_UPPER: w_op2 = {w_imm, {(DW-16){1'b0}}};
         default:   w_op2 = w_src2;
      endcase
   end

   // A load in EX has no data yet, so any enabled source that matches it must wait a cycle.
   assign w_ex_load_live = ex_we_i & ex_is_load_i & (ex_waddr_i != '0);
   assign w_hazard       = if_valid_i & w_ex_load_live &
                           ((w_oe1 & (ex_waddr_i == w_rs)) | (w_oe2 & (ex_waddr_i == w_rt)));

   assign stall_req_o = w_hazard & ~rst;
   assign reg1_oe_o   = w_oe1;
   assign reg2_oe_o   = w_oe2;
   assign reg1_addr_o = {{(DW-AW){1'b0}}, w_rs};
   assign reg2_addr_o = {{(DW-AW){1'b0}}, w_rt};

   // Reset, flush and an un-held hazard bubble all clear the register; a hold beats a bubble.
   always_ff @(posedge clk) begin
      if (rst || flush_i || (!stall_i && w_hazard)) begin
         r_valid  <= 1'b0;
         r_pc     <= '0;
         r_opcode <= '0;
         r_funct  <= '0;
         r_op1    <= '0;
         r_op2    <= '0;
         r_store  <= '0;
         r_we     <= 1'b0;
         r_waddr  <= '0;
      end else if (!stall_i) begin
         r_valid  <= if_valid_i;
         r_pc     <= if_pc_i;
         r_opcode <= w_opcode;
         r_funct  <= w_funct;
         r_op1    <= w_src1;
         r_op2    <= w_op2;
         r_store  <= w_src2;
         r_we     <= w_we;
         r_waddr  <= w_waddr;
      end
   end

   assign idex_valid_o      = r_valid;
   assign idex_pc_o         = r_pc;
   assign idex_opcode_o     = r_opcode;
   assign idex_funct_o      = r_funct;
   assign idex_op1_o        = r_op1;
   assign idex_op2_o        = r_op2;
   assign idex_store_data_o = r_store;
   assign idex_we_o         = r_we;
   assign idex_waddr_o      = r_waddr;

endmodule

// File: tb/tb_id_operand_stage.sv
// Bench for id_operand_stage: directed scenarios plus randomized cycles checked
// against an instruction-level reference model of decode, forwarding and the ID/EX register.
module tb_id_operand_stage;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, if_valid_i, flush_i, stall_i;
   logic [31:0] if_inst_i, if_pc_i;
   logic        stall_req_o, reg1_oe_o, reg2_oe_o;
   logic [31:0] reg1_addr_o, reg2_addr_o, reg1_data_i, reg2_data_i;
   logic        ex_we_i, ex_is_load_i, mem_we_i;
   logic [4:0]  ex_waddr_i, mem_waddr_i;
   logic [31:0] ex_wdata_i, mem_wdata_i;
   logic        idex_valid_o, idex_we_o;
   logic [31:0] idex_pc_o, idex_op1_o, idex_op2_o, idex_store_data_o;
   logic [5:0]  idex_opcode_o, idex_funct_o;
   logic [4:0]  idex_waddr_o;

   id_operand_stage #(.DW(32), .AW(5)) dut (
      .clk(clk), .rst(rst),
      .if_valid_i(if_valid_i), .if_inst_i(if_inst_i), .if_pc_i(if_pc_i),
      .flush_i(flush_i), .stall_i(stall_i), .stall_req_o(stall_req_o),
      .reg1_oe_o(reg1_oe_o), .reg1_addr_o(reg1_addr_o), .reg1_data_i(reg1_data_i),
      .reg2_oe_o(reg2_oe_o), .reg2_addr_o(reg2_addr_o), .reg2_data_i(reg2_data_i),
      .ex_we_i(ex_we_i), .ex_is_load_i(ex_is_load_i), .ex_waddr_i(ex_waddr_i),
      .ex_wdata_i(ex_wdata_i),
      .mem_we_i(mem_we_i), .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i),
      .idex_valid_o(idex_valid_o), .idex_pc_o(idex_pc_o),
      .idex_opcode_o(idex_opcode_o), .idex_funct_o(idex_funct_o),
      .idex_op1_o(idex_op1_o), .idex_op2_o(idex_op2_o),
      .idex_store_data_o(idex_store_data_o),
      .idex_we_o(idex_we_o), .idex_waddr_o(idex_waddr_o)
   );

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [5:0]  opc;
      logic [5:0]  fn;
      logic [31:0] op1;
      logic [31:0] op2;
      logic [31:0] sd;
      logic        we;
      logic [4:0]  wa;
   } idex_t;

   int          tests  = 0;
   int          failed = 0;
   idex_t       exp_r  = '0;
   logic [31:0] exp_q[$];

   function automatic idex_t obs();
      return {idex_valid_o, idex_pc_o, idex_opcode_o, idex_funct_o, idex_op1_o,
              idex_op2_o, idex_store_data_o, idex_we_o, idex_waddr_o};
   endfunction

   // Contents of a non-valid slot are don't-care apart from valid and we.
   function automatic idex_t mask(input idex_t x);
      idex_t m;
      m = '0;
      if (x.valid) m = x;
      else m.we = x.we;
      return m;
   endfunction

   function automatic logic [31:0] val_of(input logic [4:0] a, input logic [31:0] rf);
      if (a == 5'd0) return 32'd0;
      if (ex_we_i && ex_waddr_i == a) return ex_wdata_i;
      if (mem_we_i && mem_waddr_i == a) return mem_wdata_i;
      return rf;
   endfunction

   // Reference decode of the current IF/ID slot from the instruction-class table.
   task automatic model(output idex_t d, output logic o1, output logic o2, output logic hz);
      logic [5:0]  opc;
      logic [4:0]  rs, rt, dest;
      logic        use_rs, use_rt, has_dest;
      logic [31:0] imm_s, imm_z;
      int          kind;
      opc = if_inst_i[31:26];
      rs = if_inst_i[25:21];
      rt = if_inst_i[20:16];
      imm_z = {16'd0, if_inst_i[15:0]};
      imm_s = {{16{if_inst_i[15]}}, if_inst_i[15:0]};
      use_rs = 0; use_rt = 0; has_dest = 0; dest = rt; kind = 0;
      case (opc)
         6'h00: begin use_rs = 1; use_rt = 1; has_dest = 1; dest = if_inst_i[15:11]; end
         6'h08, 6'h09, 6'h0A, 6'h0B, 6'h23: begin use_rs = 1; has_dest = 1; kind = 1; end
         6'h0C, 6'h0D, 6'h0E: begin use_rs = 1; has_dest = 1; kind = 2; end
         6'h0F: begin has_dest = 1; kind = 3; end
         6'h2B: begin use_rs = 1; use_rt = 1; kind = 1; end
         default: ;
      endcase
      o1 = if_valid_i & use_rs;
      o2 = if_valid_i & use_rt;
      d.valid = if_valid_i;
      d.pc = if_pc_i;
      d.opc = opc;
      d.fn = if_inst_i[5:0];
      d.op1 = o1 ? val_of(rs, reg1_data_i) : 32'd0;
      d.sd = o2 ? val_of(rt, reg2_data_i) : 32'd0;
      case (kind)
         1: d.op2 = imm_s;
         2: d.op2 = imm_z;
         3: d.op2 = {if_inst_i[15:0], 16'd0};
         default: d.op2 = d.sd;
      endcase
      d.we = if_valid_i & has_dest & (dest != 5'd0);
      d.wa = has_dest ? dest : 5'd0;
      hz = if_valid_i & ex_we_i & ex_is_load_i & (ex_waddr_i != 5'd0) &
           ((o1 & ex_waddr_i == rs) | (o2 & ex_waddr_i == rt));
   endtask

   // Advance one clock and update the expected ID/EX contents.
   task automatic tick();
      idex_t d, nxt;
      logic  o1, o2, hz;
      model(d, o1, o2, hz);
      if (rst || flush_i) nxt = '0;
      else if (stall_i) nxt = exp_r;
      else if (hz) nxt = '0;
      else nxt = d;
      @(posedge clk);
      #1;
      exp_r = nxt;
   endtask

   task automatic drive_idle();
      rst = 0; if_valid_i = 0; if_inst_i = 32'd0; if_pc_i = 32'd0;
      flush_i = 0; stall_i = 0;
      reg1_data_i = $urandom; reg2_data_i = $urandom;
      ex_we_i = 0; ex_is_load_i = 0; ex_waddr_i = 5'd0; ex_wdata_i = $urandom;
      mem_we_i = 0; mem_waddr_i = 5'd0; mem_wdata_i = $urandom;
   endtask

   task automatic test_reset();
      drive_idle();
      rst = 1;
      if_valid_i = 1;
      #1;
      tests++;
      if (stall_req_o !== 1'b0) begin
         failed++; $display("FAIL reset_stall_req got=%b exp=0", stall_req_o);
      end
      tick();
      tick();
      tests++;
      if (obs() !== '0) begin
         failed++; $display("FAIL reset_idex got=%h exp=0", obs());
      end
   endtask

   task automatic test_addiu();
      drive_idle();
      if_valid_i = 1; if_pc_i = 32'h100;
      if_inst_i = {6'h09, 5'd1, 5'd3, 16'hFFFF};
      reg1_data_i = 32'd5;
      #1;
      tests++;
      if ({reg1_oe_o, reg2_oe_o, reg1_addr_o, stall_req_o} !== {1'b1, 1'b0, 32'd1, 1'b0}) begin
         failed++;
         $display("FAIL addiu_ports got oe1=%b oe2=%b a1=%h sr=%b exp 1 0 1 0",
                  reg1_oe_o, reg2_oe_o, reg1_addr_o, stall_req_o);
      end
      tick();
      tests++;
      if ({idex_valid_o, idex_op1_o, idex_op2_o, idex_we_o, idex_waddr_o, idex_pc_o} !==
          {1'b1, 32'd5, 32'hFFFFFFFF, 1'b1, 5'd3, 32'h100}) begin
         failed++;
         $display("FAIL addiu_idex got v=%b op1=%h op2=%h we=%b wa=%0d pc=%h exp 1 5 ffffffff 1 3 100",
                  idex_valid_o, idex_op1_o, idex_op2_o, idex_we_o, idex_waddr_o, idex_pc_o);
      end
   endtask

   task automatic test_forward();
      drive_idle();
      if_valid_i = 1;
      if_inst_i = {6'h00, 5'd2, 5'd2, 5'd4, 5'd0, 6'h20};
      ex_we_i = 1; ex_waddr_i = 5'd2; ex_wdata_i = 32'hA;
      mem_we_i = 1; mem_waddr_i = 5'd2; mem_wdata_i = 32'hB;
      #1;
      tests++;
      if ({reg1_oe_o, reg2_oe_o, reg1_addr_o, reg2_addr_o} !== {1'b1, 1'b1, 32'd2, 32'd2}) begin
         failed++;
         $display("FAIL fwd_ports got oe=%b%b a1=%h a2=%h exp 11 2 2",
                  reg1_oe_o, reg2_oe_o, reg1_addr_o, reg2_addr_o);
      end
      tick();
      tests++;
      if ({idex_op1_o, idex_op2_o, idex_waddr_o, idex_funct_o, idex_we_o} !==
          {32'hA, 32'hA, 5'd4, 6'h20, 1'b1}) begin
         failed++;
         $display("FAIL fwd_ex_priority got op1=%h op2=%h wa=%0d fn=%h we=%b exp a a 4 20 1",
                  idex_op1_o, idex_op2_o, idex_waddr_o, idex_funct_o, idex_we_o);
      end
   endtask

   task automatic test_load_use();
      drive_idle();
      if_valid_i = 1;
      if_inst_i = {6'h00, 5'd5, 5'd0, 5'd6, 5'd0, 6'h25};
      ex_we_i = 1; ex_is_load_i = 1; ex_waddr_i = 5'd5;
      #1;
      tests++;
      if (stall_req_o !== 1'b1) begin
         failed++; $display("FAIL load_use_stall_req got=%b exp=1", stall_req_o);
      end
      tick();
      tests++;
      if ({idex_valid_o, idex_we_o} !== 2'b00) begin
         failed++; $display("FAIL load_use_bubble got v=%b we=%b exp 0 0", idex_valid_o, idex_we_o);
      end
      ex_we_i = 0; ex_is_load_i = 0;
      mem_we_i = 1; mem_waddr_i = 5'd5; mem_wdata_i = 32'h1234;
      #1;
      tests++;
      if (stall_req_o !== 1'b0) begin
         failed++; $display("FAIL load_use_release got=%b exp=0", stall_req_o);
      end
      tick();
      tests++;
      if ({idex_valid_o, idex_op1_o, idex_waddr_o} !== {1'b1, 32'h1234, 5'd6}) begin
         failed++;
         $display("FAIL load_use_mem_fwd got v=%b op1=%h wa=%0d exp 1 1234 6",
                  idex_valid_o, idex_op1_o, idex_waddr_o);
      end
   endtask

   task automatic test_lui_ori();
      drive_idle();
      if_valid_i = 1;
      if_inst_i = {6'h0F, 5'd0, 5'd7, 16'h8000};
      #1;
      tests++;
      if ({reg1_oe_o, reg2_oe_o} !== 2'b00) begin
         failed++; $display("FAIL lui_oe got=%b%b exp=00", reg1_oe_o, reg2_oe_o);
      end
      tick();
      tests++;
      if ({idex_op2_o, idex_op1_o, idex_waddr_o} !== {32'h80000000, 32'd0, 5'd7}) begin
         failed++;
         $display("FAIL lui_op2 got op2=%h op1=%h wa=%0d exp 80000000 0 7",
                  idex_op2_o, idex_op1_o, idex_waddr_o);
      end
      if_inst_i = {6'h0D, 5'd0, 5'd8, 16'h8000};
      tick();
      tests++;
      if ({idex_op2_o, idex_op1_o, idex_waddr_o} !== {32'h00008000, 32'd0, 5'd8}) begin
         failed++;
         $display("FAIL ori_op2 got op2=%h op1=%h wa=%0d exp 8000 0 8",
                  idex_op2_o, idex_op1_o, idex_waddr_o);
      end
   endtask

   task automatic test_stall_flush();
      idex_t snap;
      drive_idle();
      if_valid_i = 1; if_pc_i = 32'h200;
      if_inst_i = {6'h09, 5'd1, 5'd2, 16'h0042};
      tick();
      snap = obs();
      tests++;
      if (mask(snap) !== mask(exp_r)) begin
         failed++; $display("FAIL stall_preload got=%h exp=%h", snap, exp_r);
      end
      stall_i = 1;
      for (int i = 0; i < 3; i++) begin
         if_inst_i = $urandom; if_pc_i = $urandom;
         reg1_data_i = $urandom; reg2_data_i = $urandom;
         tick();
         tests++;
         if (obs() !== snap) begin
            failed++; $display("FAIL stall_hold[%0d] got=%h exp=%h", i, obs(), snap);
         end
      end
      flush_i = 1;
      tick();
      tests++;
      if ({idex_valid_o, idex_we_o} !== 2'b00) begin
         failed++; $display("FAIL flush_beats_stall got v=%b we=%b exp 0 0", idex_valid_o, idex_we_o);
      end
   endtask

   task automatic test_reset_mid();
      drive_idle();
      if_valid_i = 1;
      if_inst_i = {6'h09, 5'd1, 5'd3, 16'h0001};
      tick();
      ex_we_i = 1; ex_is_load_i = 1; ex_waddr_i = 5'd1;
      rst = 1;
      #1;
      tests++;
      if (stall_req_o !== 1'b0) begin
         failed++; $display("FAIL rst_mid_stall_req got=%b exp=0", stall_req_o);
      end
      tick();
      tests++;
      if (obs() !== '0 || stall_req_o !== 1'b0) begin
         failed++; $display("FAIL rst_mid_idex got=%h sr=%b exp 0 0", obs(), stall_req_o);
      end
      rst = 0;
      #1;
      tests++;
      if (stall_req_o !== 1'b1) begin
         failed++; $display("FAIL rst_release_hazard got=%b exp=1", stall_req_o);
      end
   endtask

   task automatic test_sw_invalid();
      logic [31:0] r9, r1;
      drive_idle();
      r9 = $urandom; r1 = $urandom;
      if_valid_i = 1;
      if_inst_i = {6'h2B, 5'd1, 5'd9, 16'd4};
      reg1_data_i = r1; reg2_data_i = r9;
      tick();
      tests++;
      if ({idex_valid_o, idex_we_o, idex_store_data_o, idex_op1_o, idex_op2_o} !==
          {1'b1, 1'b0, r9, r1, 32'd4}) begin
         failed++;
         $display("FAIL sw_fields got v=%b we=%b sd=%h op1=%h op2=%h exp 1 0 %h %h 4",
                  idex_valid_o, idex_we_o, idex_store_data_o, idex_op1_o, idex_op2_o, r9, r1);
      end
      if_valid_i = 0;
      ex_we_i = 1; ex_is_load_i = 1; ex_waddr_i = 5'd1;
      #1;
      tests++;
      if ({stall_req_o, reg1_oe_o, reg2_oe_o} !== 3'b000) begin
         failed++;
         $display("FAIL invalid_slot got sr=%b oe=%b%b exp 0 00", stall_req_o, reg1_oe_o, reg2_oe_o);
      end
      tick();
      tests++;
      if ({idex_valid_o, idex_we_o} !== 2'b00) begin
         failed++; $display("FAIL invalid_idex got v=%b we=%b exp 0 0", idex_valid_o, idex_we_o);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] imm;
      logic [31:0] got_exp;
      drive_idle();
      exp_q.delete();
      for (int i = 0; i < 8; i++) begin
         imm = 16'($urandom);
         if_valid_i = 1;
         if_inst_i = {6'h09, 5'd1, 5'(i + 1), imm};
         reg1_data_i = $urandom;
         exp_q.push_back({{16{imm[15]}}, imm});
         tick();
         got_exp = exp_q.pop_front();
         tests++;
         if ({idex_valid_o, idex_op2_o, idex_waddr_o} !== {1'b1, got_exp, 5'(i + 1)}) begin
            failed++;
            $display("FAIL b2b[%0d] got v=%b op2=%h wa=%0d exp 1 %h %0d",
                     i, idex_valid_o, idex_op2_o, idex_waddr_o, got_exp, i + 1);
         end
      end
   endtask

   task automatic test_random();
      logic [5:0] ops[12] = '{6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C,
                              6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h3F};
      idex_t d;
      logic  o1, o2, hz;
      logic [5:0] opc;
      for (int i = 0; i < 400; i++) begin
         opc = ops[$urandom_range(0, 11)];
         if (opc == 6'h3F) opc = 6'($urandom);
         if_inst_i = {opc, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      5'($urandom_range(0, 3)), 11'($urandom)};
         if_pc_i = $urandom;
         if_valid_i = ($urandom_range(0, 99) < 85);
         rst = ($urandom_range(0, 99) < 2);
         flush_i = ($urandom_range(0, 99) < 8);
         stall_i = ($urandom_range(0, 99) < 15);
         reg1_data_i = $urandom; reg2_data_i = $urandom;
         ex_we_i = $urandom_range(0, 1); ex_is_load_i = $urandom_range(0, 1);
         ex_waddr_i = 5'($urandom_range(0, 3)); ex_wdata_i = $urandom;
         mem_we_i = $urandom_range(0, 1);
         mem_waddr_i = 5'($urandom_range(0, 3)); mem_wdata_i = $urandom;
         #1;
         model(d, o1, o2, hz);
         tests++;
         if ({stall_req_o, reg1_oe_o, reg2_oe_o, reg1_addr_o, reg2_addr_o} !==
             {hz & ~rst, o1, o2, 27'd0, if_inst_i[25:21], 27'd0, if_inst_i[20:16]}) begin
            failed++;
            $display("FAIL rand_comb[%0d] got sr=%b oe=%b%b a1=%h a2=%h exp sr=%b oe=%b%b",
                     i, stall_req_o, reg1_oe_o, reg2_oe_o, reg1_addr_o, reg2_addr_o,
                     hz & ~rst, o1, o2);
         end
         tick();
         tests++;
         if (mask(obs()) !== mask(exp_r)) begin
            failed++;
            $display("FAIL rand_idex[%0d] got=%h exp=%h", i, mask(obs()), mask(exp_r));
         end
      end
   endtask

   initial begin
      drive_idle();
      test_reset();
      test_addiu();
      test_forward();
      test_load_use();
      test_lui_ori();
      test_stall_flush();
      test_reset_mid();
      test_sw_invalid();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
